// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer arbiter: FSM states, player ids and the
// priority pick helper used by the first-press arbitration.
package buzzer_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int SW_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic [1:0] player_id_t;

    // First requester found when scanning upward from start, wrapping around.
    function automatic player_id_t pick_first(input logic [NUM_PLAYERS-1:0] req,
                                              input player_id_t start);
        player_id_t idx;
        player_id_t win;
        logic       found;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            idx = start + player_id_t'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One player button: 2-flop synchronizer, stable-level counter and a
// one-cycle press pulse on the accepted 0->1 transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // A new level is accepted only after it differs for DEBOUNCE_CYCLES in a row.
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Clocked first-press arbiter for the 4-player buzzer game with lockouts and round timeout.
// Define ROTATE_PRIORITY_EN for round-robin tie-break; otherwise player 1 > 2 > 3 > 4.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ROUND_CYCLES    = 500_000_000,
    parameter int TIMER_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PLAYERS-1:0]      btn,
    input  logic [NUM_PLAYERS*SW_W-1:0] sw,
    input  logic                        round_start,
    input  logic                        round_stop,
    input  logic                        ack,
    input  logic                        ack_correct,
    output logic                        playerInputFlag,
    output logic [1:0]                  firstPlayerFlag,
    output logic [SW_W-1:0]             switchInput,
    output logic                        armed,
    output logic [NUM_PLAYERS-1:0]      lockout_mask,
    output logic                        timeout,
    output state_t                      dbg_state
);

    logic [NUM_PLAYERS-1:0] press;
    logic [NUM_PLAYERS-1:0] eligible;
    logic [NUM_PLAYERS-1:0] wrong_mask;
    player_id_t             win_id;
    player_id_t             prio_start;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    player_id_t             winner_q, winner_d;
    logic [SW_W-1:0]        answer_q, answer_d;
    logic [NUM_PLAYERS-1:0] mask_q, mask_d;
    logic                   timeout_q, timeout_d;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_db
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .press (press[i])
        );
    end

`ifdef ROTATE_PRIORITY_EN
    player_id_t ptr_q, ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign prio_start = ptr_q;
`else
    assign prio_start = '0;
`endif

    assign eligible   = press & ~mask_q;
    assign win_id     = pick_first(eligible, prio_start);
    assign wrong_mask = mask_q | (4'b0001 << winner_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            winner_q  <= '0;
            answer_q  <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            winner_q  <= winner_d;
            answer_q  <= answer_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        winner_d  = winner_q;
        answer_d  = answer_q;
        mask_d    = mask_q;
        timeout_d = 1'b0;
`ifdef ROTATE_PRIORITY_EN
        ptr_d     = ptr_q;
`endif
        if (round_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (round_start) begin
                        state_d = ARMED;
                        mask_d  = '0;
                        timer_d = TIMER_W'(ROUND_CYCLES);
                    end
                end
                ARMED: begin
                    // A press on the expiry cycle wins; the timer is left untouched.
                    if (|eligible) begin
                        state_d  = LOCKED;
                        winner_d = win_id;
                        answer_d = sw[int'(win_id)*SW_W +: SW_W];
                    end else if (timer_q <= TIMER_W'(1)) begin
                        state_d   = IDLE;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                LOCKED: begin
                    if (ack) begin
                        if (ack_correct) begin
                            state_d = IDLE;
`ifdef ROTATE_PRIORITY_EN
                            ptr_d   = winner_q + 2'd1;
`endif
                        end else begin
                            mask_d = wrong_mask;
                            if (&wrong_mask) begin
                                state_d   = IDLE;
                                timeout_d = 1'b1;
                            end else begin
                                state_d = ARMED;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign playerInputFlag = (state_q == LOCKED);
    assign firstPlayerFlag = (state_q == LOCKED) ? winner_q : 2'b00;
    assign switchInput     = (state_q == LOCKED) ? answer_q : '0;
    assign armed           = (state_q == ARMED);
    assign lockout_mask    = mask_q;
    assign timeout         = timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with DEBOUNCE_CYCLES=4, ROUND_CYCLES=100.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_buzzer_arbiter;
    import buzzer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn = '0;
    logic [31:0] sw = '0;
    logic        round_start = 1'b0;
    logic        round_stop = 1'b0;
    logic        ack = 1'b0;
    logic        ack_correct = 1'b0;
    logic        playerInputFlag;
    logic [1:0]  firstPlayerFlag;
    logic [7:0]  switchInput;
    logic        armed;
    logic [3:0]  lockout_mask;
    logic        timeout;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    buzzer_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .ROUND_CYCLES    (100),
        .TIMER_W         (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn             (btn),
        .sw              (sw),
        .round_start     (round_start),
        .round_stop      (round_stop),
        .ack             (ack),
        .ack_correct     (ack_correct),
        .playerInputFlag (playerInputFlag),
        .firstPlayerFlag (firstPlayerFlag),
        .switchInput     (switchInput),
        .armed           (armed),
        .lockout_mask    (lockout_mask),
        .timeout         (timeout),
        .dbg_state       (dbg_state)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_round();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
    endtask

    task automatic press_player(input int p, input logic [7:0] swb);
        sw[p*8 +: 8] = swb;
        btn[p]       = 1'b1;
        exp_q.push_back({2'(p), swb});
    endtask

    task automatic do_ack(input logic correct);
        ack         = 1'b1;
        ack_correct = correct;
        tick();
        ack         = 1'b0;
        ack_correct = 1'b0;
    endtask

    task automatic release_all();
        btn = '0;
        ticks(8);
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_capture(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=capture expected=none queued", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_flag"}, 32'(playerInputFlag), 32'd1);
            check({tag, "_id"},   32'(firstPlayerFlag), 32'(e[9:8]));
            check({tag, "_sw"},   32'(switchInput),     32'(e[7:0]));
            check({tag, "_state"}, 32'(dbg_state),      32'(LOCKED));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_flag"}, 32'(playerInputFlag), 32'd0);
        check({tag, "_id"},   32'(firstPlayerFlag), 32'd0);
        check({tag, "_sw"},   32'(switchInput),     32'd0);
    endtask

    initial begin
        // reset state
        ticks(3);
        check_cleared("rst");
        check("rst_armed",   32'(armed),        32'd0);
        check("rst_mask",    32'(lockout_mask), 32'd0);
        check("rst_timeout", 32'(timeout),      32'd0);
        check("rst_state",   32'(dbg_state),    32'(IDLE));
        reset = 1'b0;
        tick();

        // 1. basic capture of player 2, 7 cycles after the button edge
        start_round();
        check("t1_armed", 32'(armed), 32'd1);
        press_player(1, 8'h5A);
        ticks(6);
        check("t1_early_flag", 32'(playerInputFlag), 32'd0);
        tick();
        check_capture("t1_cap");
        check("t1_armed_lk", 32'(armed), 32'd0);
        do_ack(1'b1);
        check_cleared("t1_ack");
        check("t1_state", 32'(dbg_state), 32'(IDLE));
        release_all();

        // 2. glitch rejected, then stable press of player 1 captured
        start_round();
        btn[0] = 1'b1;
        ticks(2);
        btn[0] = 1'b0;
        ticks(10);
        check("t2_glitch_flag",  32'(playerInputFlag), 32'd0);
        check("t2_glitch_armed", 32'(armed),           32'd1);
        press_player(0, 8'hC3);
        ticks(7);
        check_capture("t2_cap");
        do_ack(1'b1);
        check("t2_state", 32'(dbg_state), 32'(IDLE));
        release_all();

        // 3. players 1 and 3 together after a player 1 correct win
        start_round();
        sw[7:0]   = 8'h11;
        sw[23:16] = 8'h33;
        btn       = 4'b0101;
`ifdef ROTATE_PRIORITY_EN
        exp_q.push_back({2'd2, 8'h33});
`else
        exp_q.push_back({2'd0, 8'h11});
`endif
        ticks(7);
        check_capture("t3_tie");
        do_ack(1'b1);
        release_all();

        // 4. wrong answers build the lockout mask until everyone is out
        start_round();
        press_player(0, 8'h21);
        ticks(7);
        check_capture("t4_p1");
        do_ack(1'b0);
        check("t4_mask1",    32'(lockout_mask), 32'h1);
        check("t4_armed1",   32'(armed),        32'd1);
        check("t4_timeout1", 32'(timeout),      32'd0);
        btn[0] = 1'b0;
        ticks(8);
        btn[0] = 1'b1;
        ticks(7);
        check("t4_p1_ignored", 32'(playerInputFlag), 32'd0);
        check("t4_p1_armed",   32'(armed),           32'd1);
        press_player(1, 8'h42);
        ticks(7);
        check_capture("t4_p2");
        do_ack(1'b0);
        check("t4_mask2", 32'(lockout_mask), 32'h3);
        press_player(2, 8'h63);
        ticks(7);
        check_capture("t4_p3");
        do_ack(1'b0);
        check("t4_mask3", 32'(lockout_mask), 32'h7);
        press_player(3, 8'h84);
        ticks(7);
        check_capture("t4_p4");
        do_ack(1'b0);
        check("t4_mask4",   32'(lockout_mask), 32'hF);
        check("t4_timeout", 32'(timeout),      32'd1);
        check("t4_state",   32'(dbg_state),    32'(IDLE));
        tick();
        check("t4_timeout_end", 32'(timeout), 32'd0);
        release_all();
        check("t4_mask_hold", 32'(lockout_mask), 32'hF);

        // 5. timeout after exactly 100 armed cycles, then press on the expiry cycle
        start_round();
        check("t5_mask_clr", 32'(lockout_mask), 32'h0);
        ticks(99);
        check("t5_armed99",   32'(armed),   32'd1);
        check("t5_timeout99", 32'(timeout), 32'd0);
        tick();
        check("t5_armed100",   32'(armed),     32'd0);
        check("t5_timeout100", 32'(timeout),   32'd1);
        check("t5_state100",   32'(dbg_state), 32'(IDLE));
        tick();
        check("t5_timeout_end", 32'(timeout), 32'd0);

        start_round();
        ticks(93);
        press_player(1, 8'h77);
        ticks(6);
        check("t5_race_armed", 32'(armed),           32'd1);
        check("t5_race_flag0", 32'(playerInputFlag), 32'd0);
        tick();
        check_capture("t5_race");
        check("t5_race_timeout", 32'(timeout), 32'd0);
        tick();
        check("t5_race_timeout2", 32'(timeout),   32'd0);
        check("t5_race_state",    32'(dbg_state), 32'(LOCKED));

        // 6. asynchronous reset while locked
        reset = 1'b1;
        #1;
        check_cleared("t6_rst");
        check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        btn   = '0;
        tick();
        ticks(8);

        // 6b. round_stop beats a wrong ack; mask stays as it was
        start_round();
        press_player(2, 8'h9C);
        ticks(7);
        check_capture("t6_p3");
        do_ack(1'b0);
        check("t6_mask", 32'(lockout_mask), 32'h4);
        press_player(3, 8'hE1);
        ticks(7);
        check_capture("t6_p4");
        round_stop  = 1'b1;
        ack         = 1'b1;
        ack_correct = 1'b0;
        tick();
        round_stop  = 1'b0;
        ack         = 1'b0;
        check("t6_stop_state",   32'(dbg_state),    32'(IDLE));
        check("t6_stop_mask",    32'(lockout_mask), 32'h4);
        check("t6_stop_timeout", 32'(timeout),      32'd0);
        check_cleared("t6_stop");
        do_ack(1'b0);
        check("t6_idle_ack_mask",  32'(lockout_mask), 32'h4);
        check("t6_idle_ack_state", 32'(dbg_state),    32'(IDLE));
        release_all();

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
